// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute program-counter sequencer with single-step, halt and retire count.
module pc_sequencer #(
  parameter int PC_W     = 6,
  parameter int INSTR_W  = 16,
  parameter int START_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               step,
  input  logic               resume,
  input  logic               halt_req,
  input  logic               halt_instr,
  input  logic               c2,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ir,
  output logic               exec_en,
  output logic               halted,
  output logic               busy,
  output logic [15:0]        retired
);
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [15:0]        retired_q, retired_d;
  logic               sstep_q, sstep_d;
  logic               imem_req_q, exec_en_q, halted_q, busy_q;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retired_d = retired_q;
    sstep_d   = sstep_q;
    case (state_q)
      IDLE: begin
        state_d = (step || run) ? FETCH : IDLE;
        sstep_d = step ? 1'b1 : (run ? 1'b0 : sstep_q);
      end
      FETCH: begin
        state_d = imem_ready ? EXEC : FETCH;
        ir_d    = imem_ready ? instr_in : ir_q;
      end
      EXEC: begin
        // offset is two's complement; the PC_W-wide add wraps naturally
        pc_d      = pc_q + PC_W'(1) + (c2 ? ir_q[PC_W-1:0] : '0);
        retired_d = retired_q + 16'd1;
        sstep_d   = 1'b0;
        state_d   = (halt_instr || halt_req) ? HALT :
                    sstep_q ? IDLE : (run ? FETCH : IDLE);
      end
      HALT:    state_d = resume ? IDLE : HALT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= PC_W'(START_PC);
      ir_q       <= '0;
      retired_q  <= '0;
      sstep_q    <= 1'b0;
      imem_req_q <= 1'b0;
      exec_en_q  <= 1'b0;
      halted_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      retired_q  <= retired_d;
      sstep_q    <= sstep_d;
      imem_req_q <= state_d == FETCH;
      exec_en_q  <= state_d == EXEC;
      halted_q   <= state_d == HALT;
      busy_q     <= state_d == FETCH || state_d == EXEC;
    end
  end
  assign imem_req  = imem_req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign exec_en   = exec_en_q;
  assign halted    = halted_q;
  assign busy      = busy_q;
  assign retired   = retired_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed scenarios plus a randomized run against an observable-behaviour model.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b0, run = 1'b0, step = 1'b0, resume = 1'b0;
  logic        halt_req = 1'b0, halt_instr = 1'b0, c2 = 1'b0, imem_ready = 1'b0;
  logic [15:0] instr_in = '0;
  logic        imem_req, exec_en, halted, busy;
  logic [5:0]  imem_addr, pc;
  logic [15:0] ir, retired;
  int checks = 0, errors = 0;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .resume(resume),
    .halt_req(halt_req), .halt_instr(halt_instr), .c2(c2), .imem_ready(imem_ready),
    .instr_in(instr_in), .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc),
    .ir(ir), .exec_en(exec_en), .halted(halted), .busy(busy), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // one instruction from IDLE via a step pulse, ready on the first fetch cycle
  task automatic exec_one(input logic [15:0] w, input logic c);
    step = 1'b1;
    tick();
    step = 1'b0;
    imem_ready = 1'b1;
    instr_in = w;
    tick();
    imem_ready = 1'b0;
    c2 = c;
    tick();
    c2 = 1'b0;
  endtask

  task automatic test_reset();
    run = 1'b1; step = 1'b1; imem_ready = 1'b1; c2 = 1'b1;
    do_reset();
    run = 1'b0; step = 1'b0; imem_ready = 1'b0; c2 = 1'b0;
    checks++;
    if ({imem_req, exec_en, halted, busy} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {imem_req, exec_en, halted, busy});
    end
    checks++;
    if (pc !== 6'd0 || imem_addr !== 6'd0) begin
      errors++; $display("FAIL reset_pc: got pc=%0d addr=%0d expected 0", pc, imem_addr);
    end
    checks++;
    if (ir !== 16'd0 || retired !== 16'd0) begin
      errors++; $display("FAIL reset_regs: got ir=%0h retired=%0d expected 0", ir, retired);
    end
  endtask

  task automatic test_free_run();
    int n = 0;
    do_reset();
    run = 1'b1; imem_ready = 1'b1; c2 = 1'b0;
    for (int i = 1; i <= 129; i++) begin
      instr_in = 16'($urandom);
      tick();
      checks++;
      if (exec_en !== ((i % 2) == 0)) begin
        errors++; $display("FAIL free_run_exec cycle %0d: got %b expected %b", i, exec_en, (i % 2) == 0);
      end
      if (exec_en === 1'b1) begin
        checks++;
        if (pc !== 6'(n % 64)) begin
          errors++; $display("FAIL free_run_pc: got %0d expected %0d", pc, n % 64);
        end
        n++;
      end
    end
    checks++;
    if (retired !== 16'd64 || pc !== 6'd0) begin
      errors++; $display("FAIL free_run_end: got retired=%0d pc=%0d expected 64/0", retired, pc);
    end
    run = 1'b0; imem_ready = 1'b0;
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 5; i++) exec_one(16'h0000, 1'b0);
    checks++;
    if (pc !== 6'd5) begin
      errors++; $display("FAIL branch_setup: got pc=%0d expected 5", pc);
    end
    exec_one(16'h003E, 1'b1);
    checks++;
    if (pc !== 6'd4) begin
      errors++; $display("FAIL branch_back: got pc=%0d expected 4", pc);
    end
    exec_one(16'd55, 1'b1);
    exec_one(16'd10, 1'b1);
    checks++;
    if (pc !== 6'd7 || retired !== 16'd8) begin
      errors++; $display("FAIL branch_wrap: got pc=%0d retired=%0d expected 7/8", pc, retired);
    end
  endtask

  task automatic test_step_delay();
    int reqs = 0, execs = 0;
    logic [5:0] pc0;
    do_reset();
    exec_one(16'h0000, 1'b0);
    pc0 = pc;
    for (int i = 0; i < 10; i++) begin
      step = (i == 0) || (i == 2);
      imem_ready = (i == 4) || (i == 7);
      tick();
      reqs += int'(imem_req);
      execs += int'(exec_en);
    end
    step = 1'b0; imem_ready = 1'b0;
    checks++;
    if (reqs != 4 || execs != 1) begin
      errors++; $display("FAIL step_delay_counts: got req=%0d exec=%0d expected 4/1", reqs, execs);
    end
    checks++;
    if (busy !== 1'b0 || pc !== pc0 + 6'd1) begin
      errors++; $display("FAIL step_delay_end: got busy=%b pc=%0d expected 0/%0d", busy, pc, pc0 + 6'd1);
    end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 9; i++) exec_one(16'h0000, 1'b0);
    step = 1'b1;
    tick();
    step = 1'b0; imem_ready = 1'b1; instr_in = 16'hABC5;
    tick();
    imem_ready = 1'b0; halt_instr = 1'b1;
    tick();
    halt_instr = 1'b0;
    checks++;
    if (pc !== 6'd10 || halted !== 1'b1 || busy !== 1'b0 || retired !== 16'd10) begin
      errors++; $display("FAIL halt_enter: got pc=%0d halted=%b busy=%b retired=%0d expected 10/1/0/10", pc, halted, busy, retired);
    end
    run = 1'b1; c2 = 1'b1; imem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step = i[0];
      tick();
      checks++;
      if (halted !== 1'b1 || pc !== 6'd10 || retired !== 16'd10 || exec_en !== 1'b0 || ir !== 16'hABC5) begin
        errors++; $display("FAIL halt_hold: got halted=%b pc=%0d retired=%0d exec=%b ir=%0h", halted, pc, retired, exec_en, ir);
      end
    end
    run = 1'b0; c2 = 1'b0; imem_ready = 1'b0; step = 1'b0;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    tick();
    checks++;
    if (halted !== 1'b0 || busy !== 1'b0 || pc !== 6'd10) begin
      errors++; $display("FAIL halt_resume: got halted=%b busy=%b pc=%0d expected 0/0/10", halted, busy, pc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 12; i++) exec_one(16'h0000, 1'b0);
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || pc !== 6'd12) begin
      errors++; $display("FAIL reset_mid_setup: got req=%b pc=%0d expected 1/12", imem_req, pc);
    end
    reset = 1'b1; imem_ready = 1'b1; instr_in = 16'h1234;
    tick();
    reset = 1'b0; imem_ready = 1'b0;
    checks++;
    if (pc !== 6'd0 || ir !== 16'd0 || retired !== 16'd0 || {imem_req, exec_en, busy, halted} !== 4'b0) begin
      errors++; $display("FAIL reset_mid_fetch: got pc=%0d ir=%0h retired=%0d flags=%b", pc, ir, retired, {imem_req, exec_en, busy, halted});
    end
    step = 1'b1;
    tick();
    step = 1'b0; imem_ready = 1'b1; instr_in = 16'h0005;
    tick();
    imem_ready = 1'b0; reset = 1'b1; c2 = 1'b1;
    tick();
    reset = 1'b0; c2 = 1'b0;
    checks++;
    if (pc !== 6'd0 || ir !== 16'd0 || retired !== 16'd0 || exec_en !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_exec: got pc=%0d ir=%0h retired=%0d exec=%b busy=%b", pc, ir, retired, exec_en, busy);
    end
  endtask

  // model tracks only what is visible: which strobe is up, pc, ir, count, and the step-origin bit
  task automatic test_random();
    logic p_req, p_ex, p_hl, e_req, e_ex, e_hl, sf;
    logic [5:0] p_pc;
    logic [15:0] p_ir, p_ret, e_ir, e_ret;
    int off, e_pc;
    do_reset();
    sf = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      p_req = imem_req; p_ex = exec_en; p_hl = halted;
      p_pc = pc; p_ir = ir; p_ret = retired;
      reset = $urandom_range(0, 63) == 0;
      run = 1'($urandom_range(0, 1));
      step = $urandom_range(0, 3) == 0;
      resume = $urandom_range(0, 3) == 0;
      halt_req = $urandom_range(0, 7) == 0;
      halt_instr = $urandom_range(0, 7) == 0;
      c2 = 1'($urandom_range(0, 1));
      imem_ready = 1'($urandom_range(0, 1));
      instr_in = 16'($urandom);
      e_req = 1'b0; e_ex = 1'b0; e_hl = 1'b0;
      e_pc = int'(p_pc); e_ir = p_ir; e_ret = p_ret;
      if (reset) begin
        e_pc = 0; e_ir = '0; e_ret = '0; sf = 1'b0;
      end else if (p_hl) begin
        e_hl = !resume;
      end else if (p_ex) begin
        off = int'(p_ir[5:0]);
        if (off >= 32) off -= 64;
        e_pc = (int'(p_pc) + 1 + (c2 ? off : 0) + 64) % 64;
        e_ret = p_ret + 16'd1;
        if (halt_req || halt_instr) e_hl = 1'b1;
        else if (!sf) e_req = run;
        sf = 1'b0;
      end else if (p_req) begin
        if (imem_ready) begin e_ex = 1'b1; e_ir = instr_in; end
        else e_req = 1'b1;
      end else if (step || run) begin
        sf = step;
        e_req = 1'b1;
      end
      tick();
      checks++;
      if ({imem_req, exec_en, halted, busy} !== {e_req, e_ex, e_hl, e_req | e_ex}) begin
        errors++; $display("FAIL rand_flags cycle %0d: got %b expected %b", i, {imem_req, exec_en, halted, busy}, {e_req, e_ex, e_hl, e_req | e_ex});
      end
      checks++;
      if (pc !== 6'(e_pc) || imem_addr !== 6'(e_pc) || ir !== e_ir || retired !== e_ret) begin
        errors++; $display("FAIL rand_regs cycle %0d: got pc=%0d addr=%0d ir=%0h ret=%0d expected pc=%0d ir=%0h ret=%0d", i, pc, imem_addr, ir, retired, e_pc, e_ir, e_ret);
      end
    end
    {reset, run, step, resume, halt_req, halt_instr, c2, imem_ready} = '0;
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_branch();
    test_step_delay();
    test_halt();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
